train_segment_tracker: RTL
==========================

# train_segment_tracker

Parametrised successor to the fixed six-sensor train controller path (sync, counter, time measurement, predictor, selector, timer). It follows a train across `N_SENSORS` track sensors and measures the transit time of every segment in `tick` units. It also keeps a per-segment running-average prediction, drives the signal lights against that prediction, and raises an alarm on a timeout or an out-of-order sensor. It sits between the sensor synchronizer and the output/display modules, clocked from the frequency-divider enable.

## Interface
- `N_SENSORS`, default 6: number of sensors, legal range 2..16; there are `N_SENSORS-1` segments.
- `TW`, default 19: time counter width.
- `T_DEFAULT`, default 5000: prediction used for a segment with no history.
- `MARGIN_SHIFT`, default 2: timeout margin; timeout = pred + (pred >> MARGIN_SHIFT).
- `clk`  in  1: system clock (100 MHz).
- `rst_n`  in  1: asynchronous, active-low reset.
- `tick`  in  1: one-cycle time-base enable from the frequency divider.
- `sensor`  in  N_SENSORS: synchronized, level-high sensor inputs.
- `clear`  in  1: synchronous return to IDLE; history is kept.
- `seg_idx`  out  $clog2(N_SENSORS): current segment.
- `state`  out  2: IDLE=0, RUN=1, ALARM=2.
- `measured_t`  out  TW: last completed segment time.
- `predicted_t`  out  TW: prediction for the current segment.
- `light_green`, `light_yellow`, `light_red`, `alarm`  out  1 each.
- `done`  out  1: one-cycle pulse when the last sensor is reached.

## Operation
- Edge detection: `rise = sensor & ~sensor_q`, with `sensor_q` registered every clk. After reset `sensor_q` = 0, so a sensor already high at reset produces one edge.
- IDLE: all lights off, `alarm` 0.
  - `rise[0]` → RUN, seg=0, cnt=0, `predicted_t` = hist_valid[0] ? hist[0] : T_DEFAULT.
  - Edges on any other sensor are ignored.
- RUN:
  - `cnt` increments on `tick` and saturates at 2^TW-1.
  - Expected sensor: e = seg+1. `rise[e]` completes the segment:
    - `measured_t` ← cnt, the value before any same-cycle increment.
    - hist[seg] ← valid ? (hist+cnt)>>1, computed in TW+1 bits : cnt; valid[seg] ← 1.
    - If e == N_SENSORS-1: pulse `done`, go to IDLE.
    - Otherwise: seg++, cnt=0, `predicted_t` from hist/T_DEFAULT for the new segment.
  - `rise` on any sensor other than seg or e → ALARM. Re-trigger of the sensor at seg is ignored.
  - Timeout: cnt ≥ tmo → ALARM. tmo = pred + (pred >> MARGIN_SHIFT), computed in TW+1 bits and saturated to 2^TW-1.
  - Lights: green when cnt < pred; yellow when pred ≤ cnt < tmo; red 0.
- ALARM: red=1, alarm=1, green=yellow=0. Stays here until `clear`; `seg_idx`, `measured_t` and `predicted_t` are frozen.
- Priority within one cycle, highest first:
  1. `clear`
  2. wrong-sensor edge
  3. expected edge
  4. timeout
  - So an expected edge beats a timeout in the same cycle, and an expected edge plus a wrong edge goes to ALARM.
- History is never updated on the ALARM or clear paths.

## Timing
- Reset values:
  - state=IDLE; seg_idx, measured_t, predicted_t = 0.
  - All lights, alarm and done = 0.
  - All hist_valid = 0; cnt = 0.
- Latency: the sensor rising at the input is visible on registered outputs 2 clk later (1 cycle `sensor_q` compare, 1 cycle output register). `done` is aligned with the IDLE state.
- Lights and alarm are registered and change in the same cycle as `state`.
- `rst_n` mid-run aborts immediately and clears history. `clear` mid-run keeps history.

## Structure
- Package `train_pkg`:
  - State enum (IDLE/RUN/ALARM).
  - Light/state encodings shared with the output and display modules.
- Sub-module `segment_history`: `N_SENSORS-1` entries of TW bits plus valid bits, holding the averaging update. Read port feeds `predicted_t`; write port is the segment-complete strobe.
- Top module holds edge detect, FSM, counter and timeout compare.

## Test plan
- **Normal run, no history** (`T_DEFAULT`=5000): edges on sensors 0..5, each 1000 ticks apart.
  - Each segment gives `measured_t`=1000 with green on throughout.
  - `done` pulses once; hist[0..4]=1000.
- **Averaging:** second run with segment 0 = 3000 ticks.
  - `predicted_t`=1000 during segment 0.
  - Yellow for cnt in 1000..1249; ALARM at cnt=1250.
  - hist[0] stays 1000.
- **Out-of-order sensor:** after 0 then 1, raise sensor 3 → ALARM, red=1, seg_idx frozen at 1. `clear` → IDLE, lights off.
- **Simultaneous events:**
  - `rise[e]` on the exact cycle cnt reaches tmo → segment completes, no alarm.
  - `rise[e]` and `rise[e+1]` in the same cycle → ALARM.
- **Reset:** `rst_n` low mid-segment → all outputs 0 and history invalid. Next run uses T_DEFAULT=5000.
- **Saturation:** TW=4, T_DEFAULT=15 → tmo saturates at 15 and cnt holds at 15; ALARM is asserted when cnt reaches 15.

Source files
------------

// File: rtl/train_pkg.sv
// Shared state and light encodings for the train segment tracker
// and the output/display modules that consume its status.
package train_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_ALARM = 2'd2
    } state_t;

    typedef struct packed {
        logic red;
        logic yellow;
        logic green;
    } lights_t;

    localparam lights_t LT_OFF    = 3'b000;
    localparam lights_t LT_GREEN  = 3'b001;
    localparam lights_t LT_YELLOW = 3'b010;
    localparam lights_t LT_RED    = 3'b100;

endpackage

// File: rtl/segment_history.sv
// Per-segment transit history with running-average update;
// the read port falls back to the default when a segment has no history.
module segment_history
    import train_pkg::*;
#(
    parameter int N_SEG     = 5,
    parameter int TW        = 19,
    parameter int SW        = 3,
    parameter int T_DEFAULT = 5000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [SW-1:0] rd_idx,
    output logic [TW-1:0] rd_data,
    input  logic          wr_en,
    input  logic [SW-1:0] wr_idx,
    input  logic [TW-1:0] wr_data
);

    localparam logic [TW-1:0] T_DEF = TW'(T_DEFAULT);

    logic [TW-1:0]    hist [N_SEG];
    logic [N_SEG-1:0] valid;
    logic [TW:0]      sum;
    logic [TW-1:0]    avg;

    // Average is formed one bit wider so the carry is not lost.
    assign sum = {1'b0, hist[wr_idx]} + {1'b0, wr_data};
    assign avg = TW'(sum >> 1);

    always_comb begin
        rd_data = T_DEF;
        if (int'(rd_idx) < N_SEG) begin
            if (valid[rd_idx]) begin
                rd_data = hist[rd_idx];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
            for (int i = 0; i < N_SEG; i++) begin
                hist[i] <= '0;
            end
        end else if (wr_en) begin
            hist[wr_idx]  <= valid[wr_idx] ? avg : wr_data;
            valid[wr_idx] <= 1'b1;
        end
    end

endmodule

// File: rtl/train_segment_tracker.sv
// Follows a train across the sensor chain, times each segment and
// drives lights/alarm against the per-segment predicted transit time.
module train_segment_tracker
    import train_pkg::*;
#(
    parameter int N_SENSORS    = 6,
    parameter int TW           = 19,
    parameter int T_DEFAULT    = 5000,
    parameter int MARGIN_SHIFT = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         tick,
    input  logic [N_SENSORS-1:0]         sensor,
    input  logic                         clear,
    output logic [$clog2(N_SENSORS)-1:0] seg_idx,
    output logic [1:0]                   state,
    output logic [TW-1:0]                measured_t,
    output logic [TW-1:0]                predicted_t,
    output logic                         light_green,
    output logic                         light_yellow,
    output logic                         light_red,
    output logic                         alarm,
    output logic                         done
);

    localparam int SW   = $clog2(N_SENSORS);
    localparam int NSEG = N_SENSORS - 1;

    localparam logic [TW-1:0] CNT_MAX = '1;
    localparam logic [N_SENSORS-1:0] ONE =
        {{(N_SENSORS-1){1'b0}}, 1'b1};

    function automatic logic [TW-1:0] tmo_of(
        input logic [TW-1:0] p
    );
        logic [TW:0] s;
        s = {1'b0, p} + ({1'b0, p} >> MARGIN_SHIFT);
        return s[TW] ? CNT_MAX : s[TW-1:0];
    endfunction

    function automatic lights_t run_lights(
        input logic [TW-1:0] c,
        input logic [TW-1:0] p
    );
        lights_t l;
        l = LT_OFF;
        if (c < p) begin
            l = LT_GREEN;
        end else if (c < tmo_of(p)) begin
            l = LT_YELLOW;
        end
        return l;
    endfunction

    logic [N_SENSORS-1:0] sensor_q;
    logic [N_SENSORS-1:0] rise_q;

    state_t        st_q, st_n;
    logic [SW-1:0] seg_q, seg_n;
    logic [TW-1:0] cnt_q, cnt_n;
    logic [TW-1:0] meas_q, meas_n;
    logic [TW-1:0] pred_q, pred_n;
    lights_t       lt_q, lt_n;
    logic          done_q, done_n;

    logic [SW-1:0] e;
    logic [SW-1:0] rd_idx;
    logic [TW-1:0] rd_pred;
    logic [TW-1:0] tmo_q;
    logic [TW-1:0] cnt_inc;
    logic          wr_en;
    logic          wrong;
    logic          hit;
    logic          last;

    // Rise is registered so the FSM sees a clean one-cycle strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sensor_q <= '0;
            rise_q   <= '0;
        end else begin
            sensor_q <= sensor;
            rise_q   <= sensor & ~sensor_q;
        end
    end

    assign e       = seg_q + SW'(1);
    assign last    = (e == SW'(NSEG));
    assign wrong   = |(rise_q & ~((ONE << seg_q) | (ONE << e)));
    assign hit     = |(rise_q & (ONE << e));
    assign tmo_q   = tmo_of(pred_q);
    assign cnt_inc = (tick && cnt_q != CNT_MAX) ? cnt_q + TW'(1) : cnt_q;
    assign rd_idx  = (st_q == ST_RUN) ? e : '0;

    segment_history #(
        .N_SEG     (NSEG),
        .TW        (TW),
        .SW        (SW),
        .T_DEFAULT (T_DEFAULT)
    ) u_hist (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_idx  (rd_idx),
        .rd_data (rd_pred),
        .wr_en   (wr_en),
        .wr_idx  (seg_q),
        .wr_data (cnt_q)
    );

    always_comb begin
        st_n   = st_q;
        seg_n  = seg_q;
        cnt_n  = cnt_q;
        meas_n = meas_q;
        pred_n = pred_q;
        lt_n   = lt_q;
        done_n = 1'b0;
        wr_en  = 1'b0;
        if (clear) begin
            st_n = ST_IDLE;
            lt_n = LT_OFF;
        end else begin
            unique case (st_q)
                ST_IDLE: begin
                    if (rise_q[0]) begin
                        st_n   = ST_RUN;
                        seg_n  = '0;
                        cnt_n  = '0;
                        pred_n = rd_pred;
                        lt_n   = run_lights('0, rd_pred);
                    end
                end
                ST_RUN: begin
                    if (wrong) begin
                        st_n = ST_ALARM;
                        lt_n = LT_RED;
                    end else if (hit) begin
                        meas_n = cnt_q;
                        wr_en  = 1'b1;
                        if (last) begin
                            st_n   = ST_IDLE;
                            lt_n   = LT_OFF;
                            done_n = 1'b1;
                        end else begin
                            seg_n  = e;
                            cnt_n  = '0;
                            pred_n = rd_pred;
                            lt_n   = run_lights('0, rd_pred);
                        end
                    end else begin
                        cnt_n = cnt_inc;
                        // Alarm lands on the same edge the count reaches tmo.
                        if (cnt_inc >= tmo_q) begin
                            st_n = ST_ALARM;
                            lt_n = LT_RED;
                        end else begin
                            lt_n = run_lights(cnt_inc, pred_q);
                        end
                    end
                end
                ST_ALARM: begin
                    lt_n = LT_RED;
                end
                default: begin
                    st_n = ST_IDLE;
                    lt_n = LT_OFF;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q   <= ST_IDLE;
            seg_q  <= '0;
            cnt_q  <= '0;
            meas_q <= '0;
            pred_q <= '0;
            lt_q   <= LT_OFF;
            done_q <= 1'b0;
        end else begin
            st_q   <= st_n;
            seg_q  <= seg_n;
            cnt_q  <= cnt_n;
            meas_q <= meas_n;
            pred_q <= pred_n;
            lt_q   <= lt_n;
            done_q <= done_n;
        end
    end

    assign state        = st_q;
    assign seg_idx      = seg_q;
    assign measured_t   = meas_q;
    assign predicted_t  = pred_q;
    assign light_green  = lt_q.green;
    assign light_yellow = lt_q.yellow;
    assign light_red    = lt_q.red;
    assign alarm        = (st_q == ST_ALARM);
    assign done         = done_q;

endmodule
